// File: rtl/axil_dot_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : axil_dot_ctrl_if
//  Purpose  : AXI4-Lite bus bundle (no strobes, no prot) used by the
//             dot-product controller register block.
//  Modports : master - drives AW/W/AR valids, bready, rready
//             slave  - drives the ready signals, B and R channels
//  Revision : 1.0 - initial release
// ============================================================================
interface axil_dot_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [4:0]        araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/axil_dot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : axil_dot_ctrl
//  Purpose  : AXI4-Lite register block and phase sequencer for a dot-product
//             engine (FETCH -> COMPUTE -> WRITE).
//  Ports    : clk, rst (async, active-low)
//             axi          - AXI4-Lite slave (axil_dot_ctrl_if.slave)
//             start_fetch / start_compute / start_write - 1-cycle phase pulses
//             eng_done, eng_result - engine phase-complete and result
//             vec_a_addr, vec_b_addr, out_addr, vec_len - config registers
//             irq          - STATUS.done & CTRL.irq_en (level)
//  Register map (byte offsets):
//             0x00 CTRL   b0 start (W1S, reads 0), b1 irq_en
//             0x04 STATUS b0 busy (RO), b1 done (W1C), b2 timeout (W1C)
//             0x08 A_ADDR 0x0C B_ADDR 0x10 OUT_ADDR 0x14 LEN 0x18 RESULT (RO)
//             anything else: SLVERR, read 0, write dropped
//  Options  : `define DP_TIMEOUT_EN to abort a phase after 65535 cycles
//             without eng_done (sets STATUS.timeout).
//  Revision : 1.0 - initial release
// ============================================================================
module axil_dot_ctrl #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  wire                clk,
  input  wire                rst,
  axil_dot_ctrl_if.slave     axi,
  output logic               start_fetch,
  output logic               start_compute,
  output logic               start_write,
  input  wire                eng_done,
  input  wire [DATA_W-1:0]   eng_result,
  output logic [DATA_W-1:0]  vec_a_addr,
  output logic [DATA_W-1:0]  vec_b_addr,
  output logic [DATA_W-1:0]  out_addr,
  output logic [LEN_W-1:0]   vec_len,
  output logic               irq
);

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_COMPUTE = 2'd2,
    S_WRITE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              irq_en_q, irq_en_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] a_addr_q, a_addr_d;
  logic [DATA_W-1:0] b_addr_q, b_addr_d;
  logic [DATA_W-1:0] out_addr_q, out_addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              start_fetch_q, start_fetch_d;
  logic              start_compute_q, start_compute_d;
  logic              start_write_q, start_write_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
`ifdef DP_TIMEOUT_EN
  logic [15:0]       cnt_q, cnt_d;
`endif

  logic              w_wr_hs;
  logic              w_rd_hs;
  logic              w_busy;
  logic              w_start_req;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_err;
  logic              w_unused;

  // Ready outputs are combinational; gating with rst keeps them low while
  // reset is asserted so no transfer is accepted during reset.
  assign w_wr_hs     = rst & axi.awvalid & axi.wvalid & ~bvalid_q;
  assign axi.awready = w_wr_hs;
  assign axi.wready  = w_wr_hs;
  assign axi.arready = rst & ~rvalid_q;
  assign w_rd_hs     = axi.arvalid & axi.arready;
  assign w_busy      = (state_q != S_IDLE);

  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  assign start_fetch   = start_fetch_q;
  assign start_compute = start_compute_q;
  assign start_write   = start_write_q;
  assign vec_a_addr    = a_addr_q;
  assign vec_b_addr    = b_addr_q;
  assign out_addr      = out_addr_q;
  assign vec_len       = len_q;
  assign irq           = done_q & irq_en_q;

  // Byte-lane bits of the addresses carry no information (word aligned).
  assign w_unused = ^{axi.awaddr[1:0], axi.araddr[1:0]};

  // Read mux works on current register contents, so a read coincident with
  // a write (including a STATUS W1C) returns the pre-write value.
  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (axi.araddr[4:2])
      3'd0: w_rd_data[1]       = irq_en_q;
      3'd1: w_rd_data[2:0]     = {timeout_q, done_q, w_busy};
      3'd2: w_rd_data          = a_addr_q;
      3'd3: w_rd_data          = b_addr_q;
      3'd4: w_rd_data          = out_addr_q;
      3'd5: w_rd_data[LEN_W-1:0] = len_q;
      3'd6: w_rd_data          = result_q;
      default: w_rd_err        = 1'b1;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    irq_en_d        = irq_en_q;
    done_d          = done_q;
    timeout_d       = timeout_q;
    a_addr_d        = a_addr_q;
    b_addr_d        = b_addr_q;
    out_addr_d      = out_addr_q;
    len_d           = len_q;
    result_d        = result_q;
    start_fetch_d   = 1'b0;
    start_compute_d = 1'b0;
    start_write_d   = 1'b0;
    bvalid_d        = bvalid_q;
    bresp_d         = bresp_q;
    rvalid_d        = rvalid_q;
    rdata_d         = rdata_q;
    rresp_d         = rresp_q;
    w_start_req     = 1'b0;
`ifdef DP_TIMEOUT_EN
    cnt_d           = cnt_q;
`endif

    // Response channels: hold until accepted.
    if (bvalid_q && axi.bready) bvalid_d = 1'b0;
    if (rvalid_q && axi.rready) rvalid_d = 1'b0;

    if (w_rd_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = w_rd_data;
      rresp_d  = w_rd_err ? c_resp_slverr : c_resp_okay;
    end

    // Register writes. Config writes while busy are dropped but still OKAY.
    if (w_wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = c_resp_okay;
      case (axi.awaddr[4:2])
        3'd0: begin
          irq_en_d = axi.wdata[1];
          if (axi.wdata[0] && !w_busy) w_start_req = 1'b1;
        end
        3'd1: begin
          if (axi.wdata[1]) done_d    = 1'b0;
          if (axi.wdata[2]) timeout_d = 1'b0;
        end
        3'd2: if (!w_busy) a_addr_d   = axi.wdata;
        3'd3: if (!w_busy) b_addr_d   = axi.wdata;
        3'd4: if (!w_busy) out_addr_d = axi.wdata;
        3'd5: if (!w_busy) len_d      = axi.wdata[LEN_W-1:0];
        3'd6: ;
        default: bresp_d = c_resp_slverr;
      endcase
    end

    // Phase sequencer; FSM-driven status updates take priority over W1C.
    case (state_q)
      S_IDLE: begin
        if (w_start_req) begin
          done_d    = 1'b0;
          timeout_d = 1'b0;
          if (len_q == '0) begin
            // Empty vector: finish immediately without touching the engine.
            result_d = '0;
            done_d   = 1'b1;
          end else begin
            state_d       = S_FETCH;
            start_fetch_d = 1'b1;
`ifdef DP_TIMEOUT_EN
            cnt_d         = '0;
`endif
          end
        end
      end
      S_FETCH: begin
        if (eng_done) begin
          state_d         = S_COMPUTE;
          start_compute_d = 1'b1;
`ifdef DP_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end
      end
      S_COMPUTE: begin
        if (eng_done) begin
          result_d      = eng_result;
          state_d       = S_WRITE;
          start_write_d = 1'b1;
`ifdef DP_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end
      S_WRITE: begin
        if (eng_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef DP_TIMEOUT_EN
    // cnt_q counts completed idle cycles of the current phase; the cycle in
    // which it reads 65534 is the 65535th without eng_done.
    if (w_busy && !eng_done) begin
      if (cnt_q == 16'hFFFE) begin
        state_d   = S_IDLE;
        timeout_d = 1'b1;
        done_d    = 1'b0;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      irq_en_q        <= 1'b0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      a_addr_q        <= '0;
      b_addr_q        <= '0;
      out_addr_q      <= '0;
      len_q           <= '0;
      result_q        <= '0;
      start_fetch_q   <= 1'b0;
      start_compute_q <= 1'b0;
      start_write_q   <= 1'b0;
      bvalid_q        <= 1'b0;
      bresp_q         <= 2'b00;
      rvalid_q        <= 1'b0;
      rdata_q         <= '0;
      rresp_q         <= 2'b00;
`ifdef DP_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      irq_en_q        <= irq_en_d;
      done_q          <= done_d;
      timeout_q       <= timeout_d;
      a_addr_q        <= a_addr_d;
      b_addr_q        <= b_addr_d;
      out_addr_q      <= out_addr_d;
      len_q           <= len_d;
      result_q        <= result_d;
      start_fetch_q   <= start_fetch_d;
      start_compute_q <= start_compute_d;
      start_write_q   <= start_write_d;
      bvalid_q        <= bvalid_d;
      bresp_q         <= bresp_d;
      rvalid_q        <= rvalid_d;
      rdata_q         <= rdata_d;
      rresp_q         <= rresp_d;
`ifdef DP_TIMEOUT_EN
      cnt_q           <= cnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_dot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_dot_ctrl
//  Purpose  : Directed self-checking bench for axil_dot_ctrl: register
//             access, phase sequencing, irq, empty vector, SLVERR, B-channel
//             backpressure, coincident read/W1C and reset mid-operation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axil_dot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_fetch, start_compute, start_write;
  logic        eng_done = 1'b0;
  logic [31:0] eng_result = '0;
  logic [31:0] vec_a_addr, vec_b_addr, out_addr;
  logic [15:0] vec_len;
  logic        irq;

  axil_dot_ctrl_if #(.DATA_W(32)) bus ();

  axil_dot_ctrl #(.DATA_W(32), .LEN_W(16)) dut (
    .clk           (clk),
    .rst           (rst_n),
    .axi           (bus),
    .start_fetch   (start_fetch),
    .start_compute (start_compute),
    .start_write   (start_write),
    .eng_done      (eng_done),
    .eng_result    (eng_result),
    .vec_a_addr    (vec_a_addr),
    .vec_b_addr    (vec_b_addr),
    .out_addr      (out_addr),
    .vec_len       (vec_len),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: counts high cycles and stamps the last cycle seen.
  int cyc = 0, n_fetch = 0, n_comp = 0, n_write = 0;
  int t_fetch = 0, t_comp = 0, t_write = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (start_fetch)   begin n_fetch <= n_fetch + 1; t_fetch <= cyc; end
    if (start_compute) begin n_comp  <= n_comp + 1;  t_comp  <= cyc; end
    if (start_write)   begin n_write <= n_write + 1; t_write <= cyc; end
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    while (!bus.awready && n < 100) begin @(negedge clk); #1; n++; end
    check("aw_accept", bus.awready, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 100) begin @(negedge clk); n++; end
    check("b_valid", bus.bvalid, 1'b1);
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1;
    #1;
    while (!bus.arready && n < 100) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 100) begin @(negedge clk); n++; end
    check("r_valid", bus.rvalid, 1'b1);
    d = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic done_pulse(input logic [31:0] r);
    @(negedge clk);
    eng_done = 1'b1; eng_result = r;
    @(negedge clk);
    eng_done = 1'b0;
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;
  int bf, bc, bw;

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_arready", bus.arready, 1'b0);
    check("rst_pulses", {start_fetch, start_compute, start_write}, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    axi_read(5'h04, rd, resp); check("rst_status", rd, 32'h0);
    axi_read(5'h00, rd, resp); check("rst_ctrl", rd, 32'h0);
    check("rst_irq", irq, 1'b0);

    // Config writes and readback
    axi_write(5'h08, 32'h1000, resp); check("wr_a_resp", resp, 2'b00);
    axi_write(5'h0C, 32'h2000, resp); check("wr_b_resp", resp, 2'b00);
    axi_write(5'h14, 32'h0000_0004, resp); check("wr_len_resp", resp, 2'b00);
    axi_write(5'h10, 32'h3000, resp); check("wr_out_resp", resp, 2'b00);
    axi_read(5'h08, rd, resp); check("rd_a", rd, 32'h1000); check("rd_a_resp", resp, 2'b00);
    axi_read(5'h0C, rd, resp); check("rd_b", rd, 32'h2000);
    axi_read(5'h10, rd, resp); check("rd_out", rd, 32'h3000);
    axi_read(5'h14, rd, resp); check("rd_len", rd, 32'h4);
    check("o_a", vec_a_addr, 32'h1000);
    check("o_b", vec_b_addr, 32'h2000);
    check("o_out", out_addr, 32'h3000);
    check("o_len", vec_len, 16'h4);
    axi_write(5'h14, 32'hABCD_0004, resp);
    axi_read(5'h14, rd, resp); check("rd_len_trunc", rd, 32'h4);

    // Full run, irq disabled
    bf = n_fetch; bc = n_comp; bw = n_write;
    axi_write(5'h00, 32'h1, resp); check("start_resp", resp, 2'b00);
    axi_read(5'h04, rd, resp); check("status_busy", rd, 32'h1);
    axi_write(5'h08, 32'hDEAD, resp); check("busy_wr_resp", resp, 2'b00);
    axi_read(5'h08, rd, resp); check("busy_wr_dropped", rd, 32'h1000);
    done_pulse(32'd99);           // FETCH -> COMPUTE
    done_pulse(32'd50);           // COMPUTE -> WRITE, result latched
    done_pulse(32'd7);            // WRITE -> IDLE
    repeat (2) @(negedge clk);
    check("n_fetch", n_fetch - bf, 1);
    check("n_comp", n_comp - bc, 1);
    check("n_write", n_write - bw, 1);
    check("pulse_order", (t_fetch < t_comp) && (t_comp < t_write), 1'b1);
    axi_read(5'h18, rd, resp); check("result", rd, 32'd50);
    axi_read(5'h04, rd, resp); check("status_done", rd, 32'h2);
    check("irq_off", irq, 1'b0);
    done_pulse(32'd1);            // ignored in IDLE
    repeat (2) @(negedge clk);
    check("idle_done_ign", n_fetch - bf + n_comp - bc + n_write - bw, 3);
    axi_read(5'h18, rd, resp); check("idle_result_kept", rd, 32'd50);

    // irq
    axi_write(5'h00, 32'h3, resp);
    check("irq_clr_on_start", irq, 1'b0);
    axi_read(5'h00, rd, resp); check("ctrl_rd", rd, 32'h2);
    done_pulse(32'd0); done_pulse(32'd77); done_pulse(32'd0);
    @(negedge clk);
    check("irq_set", irq, 1'b1);
    axi_write(5'h04, 32'h2, resp);
    check("irq_w1c", irq, 1'b0);
    axi_read(5'h04, rd, resp); check("status_w1c", rd, 32'h0);
    axi_read(5'h18, rd, resp); check("result2", rd, 32'd77);

    // Empty vector
    axi_write(5'h14, 32'h0, resp);
    bf = n_fetch; bc = n_comp; bw = n_write;
    axi_write(5'h00, 32'h1, resp);
    axi_read(5'h04, rd, resp); check("len0_status", rd, 32'h2);
    axi_read(5'h18, rd, resp); check("len0_result", rd, 32'h0);
    check("len0_no_pulse", n_fetch - bf + n_comp - bc + n_write - bw, 0);

    // Coincident STATUS read and W1C returns pre-clear value
    @(negedge clk);
    bus.awaddr = 5'h04; bus.wdata = 32'h2; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 5'h04; bus.arvalid = 1'b1;
    #1;
    check("coinc_aw", bus.awready, 1'b1);
    check("coinc_ar", bus.arready, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("coinc_rdata", bus.rdata, 32'h2);
    bus.rready = 1'b1; bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0; bus.bready = 1'b0;
    axi_read(5'h04, rd, resp); check("coinc_after", rd, 32'h0);

    // Decode errors and B-channel backpressure
    axi_read(5'h1C, rd, resp);
    check("err_rresp", resp, 2'b10); check("err_rdata", rd, 32'h0);
    @(negedge clk);
    bus.awaddr = 5'h1C; bus.wdata = 32'h1234; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1; check("err_aw", bus.awready, 1'b1);
    @(posedge clk); #1;
    bus.awaddr = 5'h08; bus.wdata = 32'h5555;   // second write kept pending
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_bvalid", bus.bvalid, 1'b1);
      check("hold_noaccept", bus.awready, 1'b0);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("err_bresp", bus.bresp, 2'b10);
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check("b_released", bus.bvalid, 1'b0);
    axi_read(5'h08, rd, resp); check("pending_dropped", rd, 32'h1000);

    // Reset during COMPUTE
    axi_write(5'h14, 32'h4, resp);
    axi_write(5'h00, 32'h3, resp);
    done_pulse(32'd0);            // now in COMPUTE
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_pulses", {start_fetch, start_compute, start_write}, 3'b000);
    check("arst_regs", {vec_a_addr, vec_len}, 48'h0);
    check("arst_irq_valids", {irq, bus.bvalid, bus.rvalid, bus.arready}, 4'b0000);
    bf = n_fetch; bc = n_comp; bw = n_write;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_no_pulse", n_fetch - bf + n_comp - bc + n_write - bw, 0);
    axi_read(5'h04, rd, resp); check("arst_status", rd, 32'h0);
    axi_read(5'h14, rd, resp); check("arst_len", rd, 32'h0);

`ifdef DP_TIMEOUT_EN
    axi_write(5'h14, 32'h1, resp);
    axi_write(5'h00, 32'h1, resp);
    repeat (65000) @(negedge clk);
    axi_read(5'h04, rd, resp); check("to_busy", rd, 32'h1);
    repeat (600) @(negedge clk);
    axi_read(5'h04, rd, resp); check("to_status", rd, 32'h4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
